regfile_sb: RTL and testbench

Parametrised multi-port integer register file with an integrated write-pending scoreboard, the successor to the fixed 32x32, two-read-port register file in the CPU datapath. It provides NRD combinational read ports, one synchronous write (writeback) port, and one issue port that marks a destination register as pending until its writeback arrives. Decode uses the per-port busy flags to stall on RAW hazards. Register 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 82 ++++++++
 tb/tb_regfile_sb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with write-pending scoreboard.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  // Hardwired-zero register index
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DEFAULT_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: busy vector, pending count, orphan-writeback pulse and
// per-port busy lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [ADDR_W:0]       busy_cnt,
  output logic                  wb_orphan
);

  localparam int Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [Depth-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             orphan_q, orphan_d;
  logic             wr_valid, iss_valid;

  assign wr_valid  = wr_en && (wr_addr != ZeroAddr);
  assign iss_valid = iss_en && (iss_addr != ZeroAddr);

  always_comb begin
    busy_d = busy_q;
    // Clear before set so a same-cycle issue to the written register wins.
    if (wr_valid) busy_d[wr_addr] = 1'b0;
    if (iss_valid) busy_d[iss_addr] = 1'b1;
    orphan_d = wr_valid && !busy_q[wr_addr];
    cnt_d = '0;
    for (int i = 0; i < Depth; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_lookup
    assign rd_busy[g] = busy_q[rd_addr[g*ADDR_W +: ADDR_W]];
  end

  assign busy_cnt  = cnt_q;
  assign wb_orphan = orphan_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with integrated write-pending scoreboard; r0 reads as zero.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [ADDR_W:0]       busy_cnt,
  output logic                  wb_orphan
);

  localparam int Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [Depth];
  logic [NRD-1:0]    sb_busy;
  logic              wr_valid;

  assign wr_valid = wr_en && (wr_addr != ZeroAddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_busy   (sb_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy_cnt  (busy_cnt),
    .wb_orphan (wb_orphan)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      data = (addr == ZeroAddr) ? '0 : regs_q[addr];
      busy = sb_busy[g];
`ifdef REGFILE_BYPASS_EN
      // Forward the writeback; busy reflects the post-edge state of the register.
      if (wr_valid && (addr == wr_addr)) begin
        data = wr_data;
        busy = iss_en && (iss_addr == wr_addr);
      end
`endif
    end

    assign rd_data[g*DATA_W +: DATA_W] = data;
    assign rd_busy[g]                  = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by randomized traffic,
// all checked against an array-based reference model.
module tb_regfile_sb;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [AW:0]         busy_cnt;
  logic                wb_orphan;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DW-1:0] m_reg [32];
  logic [31:0]   m_busy;
  logic          m_orphan;

  regfile_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NRD    (NRD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy_cnt  (busy_cnt),
    .wb_orphan (wb_orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    reset  = 1'b0;
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Check combinational reads, clock once, advance the model, check registered outputs.
  task automatic cycle();
    int a;
    logic [DW-1:0] exp_d;
    logic exp_b;
    #1;
    for (int p = 0; p < NRD; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      exp_d = (a == 0) ? '0 : m_reg[a];
      exp_b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (!reset && wr_en && wr_addr != 0 && int'(wr_addr) == a) begin
        exp_d = wr_data;
        exp_b = iss_en && (iss_addr == wr_addr);
      end
`endif
      check($sformatf("rd_data%0d[r%0d]", p, a), 64'(rd_data[p*DW +: DW]), 64'(exp_d));
      check($sformatf("rd_busy%0d[r%0d]", p, a), 64'(rd_busy[p]), 64'(exp_b));
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_busy   = '0;
      m_orphan = 1'b0;
    end else begin
      m_orphan = wr_en && (wr_addr != 0) && !m_busy[wr_addr];
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
    #1;
    check("busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
    check("wb_orphan", 64'(wb_orphan), 64'(m_orphan));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_busy   = '0;
    m_orphan = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_addr = '0;
    idle();

    reset = 1'b1;
    cycle();
    cycle();
    idle();

    // Every address reads zero and not busy after reset
    for (int a = 0; a < 32; a++) begin
      set_rd(0, a);
      set_rd(1, 31 - a);
      cycle();
    end

    // Issue r5, writeback two cycles later
    set_rd(0, 5);
    set_rd(1, 5);
    iss_en = 1'b1; iss_addr = 5;
    cycle();
    idle();
    check("r5_busy_after_issue", 64'(rd_busy[0]), 64'd1);
    check("r5_cnt_after_issue", 64'(busy_cnt), 64'd1);
    cycle();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    cycle();
    idle();
    #1;
    check("r5_data", 64'(rd_data[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    check("r5_busy_cleared", 64'(rd_busy[0]), 64'd0);
    check("r5_no_orphan", 64'(wb_orphan), 64'd0);
    check("r5_cnt_back", 64'(busy_cnt), 64'd0);

    // Same-cycle issue and writeback of r7: data written, stays busy
    set_rd(0, 7);
    iss_en = 1'b1; iss_addr = 7;
    wr_en  = 1'b1; wr_addr = 7; wr_data = 32'h11;
    cycle();
    idle();
    #1;
    check("r7_data", 64'(rd_data[DW-1:0]), 64'h11);
    check("r7_busy", 64'(rd_busy[0]), 64'd1);
    check("r7_cnt", 64'(busy_cnt), 64'd1);
    check("r7_orphan", 64'(wb_orphan), 64'd1);

    // Writeback r9 without issue: orphan pulse for one cycle
    set_rd(0, 9);
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h55;
    cycle();
    idle();
    check("r9_orphan", 64'(wb_orphan), 64'd1);
    cycle();
    check("r9_orphan_gone", 64'(wb_orphan), 64'd0);
    check("r9_data", 64'(rd_data[DW-1:0]), 64'h55);

    // Write and issue r0: ignored
    set_rd(0, 0);
    wr_en  = 1'b1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 0;
    cycle();
    idle();
    #1;
    check("r0_data", 64'(rd_data[DW-1:0]), 64'd0);
    check("r0_busy", 64'(rd_busy[0]), 64'd0);
    check("r0_cnt", 64'(busy_cnt), 64'd1);
    check("r0_orphan", 64'(wb_orphan), 64'd0);

    // Same-cycle writeback r3 with port 0 reading r3 (bypass-dependent)
    set_rd(0, 3);
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'hA5;
    cycle();
    idle();
    cycle();
    check("r3_next_cycle", 64'(rd_data[DW-1:0]), 64'hA5);

    // Retire r7, then four pending registers, then mid-stream reset
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h77;
    cycle();
    idle();
    for (int r = 1; r <= 4; r++) begin
      iss_en = 1'b1; iss_addr = AW'(r);
      cycle();
    end
    idle();
    check("four_busy", 64'(busy_cnt), 64'd4);
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 2; wr_data = 32'h1234;
    iss_en = 1'b1; iss_addr = 6;
    cycle();
    idle();
    check("reset_cnt", 64'(busy_cnt), 64'd0);
    set_rd(0, 2);
    set_rd(1, 6);
    cycle();

    // Randomized traffic, biased toward a few registers to create collisions
    for (int n = 0; n < 2000; n++) begin
      reset    = ($urandom_range(0, 63) == 0);
      wr_en    = ($urandom_range(0, 2) != 0);
      iss_en   = ($urandom_range(0, 2) != 0);
      wr_addr  = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      iss_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
      wr_data  = $urandom;
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 3) == 0) set_rd(p, int'(wr_addr));
        else set_rd(p, int'($urandom_range(0, 31)));
      end
      cycle();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
